// File: rtl/mean_led_sched.sv
// Frame-rate scheduler: snapshots the 8-region RGB sums on frame-done, then streams
// one saturated 8-bit-per-channel mean per region to the LED driver over valid/ready.
module mean_led_sched #(
    parameter int SUM_W = 21,
    parameter int N_REG = 8,
    parameter int SHIFT = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [SUM_W-1:0] SumR [N_REG],
    input  logic [SUM_W-1:0] SumG [N_REG],
    input  logic [SUM_W-1:0] SumB [N_REG],
    output logic             led_valid,
    input  logic             led_ready,
    output logic [2:0]       led_idx,
    output logic [23:0]      led_rgb,
    output logic             led_last,
    output logic             busy,
    output logic             frame_done,
    output logic [7:0]       drop_cnt
);

    localparam int PTR_W = (N_REG > 1) ? $clog2(N_REG) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_REG - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] SEND    = 2'd2;

    logic [1:0]       state;
    logic [PTR_W-1:0] ptr;
    logic [SUM_W-1:0] snap_r [N_REG];
    logic [SUM_W-1:0] snap_g [N_REG];
    logic [SUM_W-1:0] snap_b [N_REG];

    logic accept;
    logic final_accept;
    logic take;
    logic drop;

    // Mean by truncating shift; anything that does not fit in 8 bits clamps to 255.
    function automatic logic [7:0] sat8(input logic [SUM_W-1:0] s);
        logic [SUM_W-1:0] m;
        m = s >> SHIFT;
        return (m > SUM_W'(255)) ? 8'hFF : m[7:0];
    endfunction

    assign accept       = (state == SEND) && led_valid && led_ready;
    assign final_accept = accept && (ptr == LAST_PTR);
    // A start on the final accept chains straight into the next frame instead of dropping.
    assign take         = en && start && ((state == IDLE) || final_accept);
    assign drop         = en && start && (state != IDLE) && !final_accept;
    assign busy         = (state != IDLE);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            led_valid  <= 1'b0;
            led_last   <= 1'b0;
            led_idx    <= '0;
            led_rgb    <= '0;
            frame_done <= 1'b0;
            drop_cnt   <= '0;
            // NOTE: the snapshot array is cleared too, so a reset frame never leaks stale sums.
            for (int i = 0; i < N_REG; i++) begin
                snap_r[i] <= '0;
                snap_g[i] <= '0;
                snap_b[i] <= '0;
            end
        end else begin
            frame_done <= 1'b0;

            // The accumulator clears its sums on the next edge, so capture on this one.
            if (take) begin
                snap_r <= SumR;
                snap_g <= SumG;
                snap_b <= SumB;
                ptr    <= '0;
            end

            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (take) begin
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    led_rgb   <= {sat8(snap_r[ptr]), sat8(snap_g[ptr]), sat8(snap_b[ptr])};
                    led_idx   <= 3'(ptr);
                    led_last  <= (ptr == LAST_PTR);
                    led_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (accept) begin
                        led_valid <= 1'b0;
                        if (final_accept) begin
                            frame_done <= 1'b1;
                            led_last   <= 1'b0;
                            state      <= take ? COMPUTE : IDLE;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= COMPUTE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mean_led_sched.sv
// Scoreboarded bench for mean_led_sched: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_mean_led_sched;

    localparam int SUM_W = 21;
    localparam int N_REG = 8;
    localparam int SHIFT = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             start = 1'b0;
    logic             led_ready = 1'b0;
    logic [SUM_W-1:0] sum_r [N_REG];
    logic [SUM_W-1:0] sum_g [N_REG];
    logic [SUM_W-1:0] sum_b [N_REG];
    logic             led_valid;
    logic [2:0]       led_idx;
    logic [23:0]      led_rgb;
    logic             led_last;
    logic             busy;
    logic             frame_done;
    logic [7:0]       drop_cnt;

    int checks = 0;
    int failures = 0;
    logic [27:0] exp_q [$];
    bit b2b;

    always #5 clk = ~clk;

    mean_led_sched #(.SUM_W(SUM_W), .N_REG(N_REG), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .start     (start),
        .SumR      (sum_r),
        .SumG      (sum_g),
        .SumB      (sum_b),
        .led_valid (led_valid),
        .led_ready (led_ready),
        .led_idx   (led_idx),
        .led_rgb   (led_rgb),
        .led_last  (led_last),
        .busy      (busy),
        .frame_done(frame_done),
        .drop_cnt  (drop_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [SUM_W-1:0] r, input logic [SUM_W-1:0] g,
                           input logic [SUM_W-1:0] b);
        for (int i = 0; i < N_REG; i++) begin
            sum_r[i] = r;
            sum_g[i] = g;
            sum_b[i] = b;
        end
    endtask

    task automatic push(input int idx, input logic [23:0] rgb);
        exp_q.push_back({(idx == N_REG - 1), 3'(idx), rgb});
    endtask

    // Hand-computed patterns: 972000>>12 = 237 (0xED); 0x1FFFFF>>12 = 511 -> 255;
    // 4096>>12 = 1; 4095>>12 = 0; (5<<12)+7 -> 5.
    task automatic load_pattern(input int p);
        case (p)
            0: begin
                set_all(21'd972000, 21'd972000, 21'd972000);
                sum_r[0] = 21'h1FFFFF;
                sum_g[0] = 21'd4096;
                sum_b[0] = 21'd4095;
                push(0, 24'hFF0100);
                for (int i = 1; i < N_REG; i++) push(i, 24'hEDEDED);
            end
            1: begin
                for (int i = 0; i < N_REG; i++) begin
                    sum_r[i] = SUM_W'((i << 12) + 100);
                    sum_g[i] = SUM_W'((16 * i) << 12);
                    sum_b[i] = SUM_W'(((255 - i) << 12) + 4095);
                    push(i, {8'(i), 8'(16 * i), 8'(255 - i)});
                end
            end
            2: begin
                set_all(21'd972000, 21'd972000, 21'd972000);
                for (int i = 0; i < N_REG; i++) push(i, 24'hEDEDED);
            end
            default: begin
                set_all(21'h5007, 21'h5007, 21'h5007);
                for (int i = 0; i < N_REG; i++) push(i, 24'h050505);
            end
        endcase
    endtask

    // Issues start, zeroes the sums right after the capture edge, checks first-valid latency.
    task automatic start_frame(input int p);
        load_pattern(p);
        start = 1'b1;
        tick;
        start = 1'b0;
        set_all('0, '0, '0);
        check("start_valid_low", {31'd0, led_valid}, 0);
        check("start_busy", {31'd0, busy}, 1);
        tick;
        check("first_valid", {28'd0, led_valid, led_idx}, {28'd0, 1'b1, 3'd0});
    endtask

    task automatic drive_frame(input int stall_idx, input int drop_idx, input int next_p,
                               output bit chained);
        int stall_n;
        bit drop_done;
        bit last_acc;
        bit done;
        stall_n = 0;
        drop_done = 0;
        last_acc = 0;
        done = 0;
        chained = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (frame_done) begin
                done = 1;
                check("done_after_last_accept", {31'd0, last_acc}, 1);
                check("done_outputs", {30'd0, led_valid, led_last}, 0);
            end else begin
                start = 1'b0;
                led_ready = 1'b1;
                if (led_valid) begin
                    if (int'(led_idx) == stall_idx && stall_n < 10) begin
                        led_ready = 1'b0;
                        stall_n++;
                        check("stall_hold", {4'd0, led_last, led_idx, led_rgb},
                              (exp_q.size() != 0) ? {4'd0, exp_q[0]} : 32'hFFFFFFFF);
                    end
                    if (int'(led_idx) == drop_idx && !drop_done) begin
                        start = 1'b1;
                        drop_done = 1;
                        set_all('1, '1, '1);
                    end
                    if (next_p >= 0 && int'(led_idx) == N_REG - 1 && led_ready) begin
                        load_pattern(next_p);
                        start = 1'b1;
                        chained = 1;
                    end
                end
                last_acc = led_valid && led_ready && (int'(led_idx) == N_REG - 1);
                tick;
            end
        end
        if (!done) check("frame_done_timeout", {31'd0, frame_done}, 1);
        start = 1'b0;
    endtask

    // Monitor: every beat the driver accepts must match the head of the scoreboard.
    initial begin
        logic [27:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n && led_valid && led_ready) begin
                check("beat_expected", {31'd0, exp_q.size() != 0}, 1);
                if (exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    check("beat", {4'd0, led_last, led_idx, led_rgb}, {4'd0, exp});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        set_all('0, '0, '0);
        rst_n = 1'b0;
        tick;
        tick;
        check("rst_outputs", {led_valid, led_last, busy, frame_done, led_idx, led_rgb}, 0);
        check("rst_drop", {24'd0, drop_cnt}, 0);
        rst_n = 1'b1;
        en = 1'b1;
        led_ready = 1'b1;

        // Saturation/boundary on region 0, uniform 237 elsewhere, snapshot-timing.
        start_frame(0);
        drive_frame(-1, -1, -1, b2b);
        check("idle_busy", {31'd0, busy}, 0);
        tick;
        check("done_pulse_len", {31'd0, frame_done}, 0);
        check("drop_none", {24'd0, drop_cnt}, 0);

        // Ramp pattern, 10-cycle stall on beat 3, busy start during beat 2.
        start_frame(1);
        drive_frame(3, 2, -1, b2b);
        check("drop_one", {24'd0, drop_cnt}, 1);
        tick;

        // Start coincident with the final accept chains a new frame.
        start_frame(2);
        drive_frame(-1, -1, 3, b2b);
        set_all('0, '0, '0);
        check("b2b_started", {31'd0, b2b}, 1);
        check("b2b_busy", {31'd0, busy}, 1);
        check("b2b_no_drop", {24'd0, drop_cnt}, 1);
        tick;
        check("b2b_first_valid", {28'd0, led_valid, led_idx}, {28'd0, 1'b1, 3'd0});
        drive_frame(-1, -1, -1, b2b);
        tick;

        // 300 starts while stalled saturate drop_cnt; outputs stay put.
        led_ready = 1'b0;
        start_frame(2);
        for (int i = 0; i < 300; i++) begin
            start = 1'b1;
            tick;
        end
        start = 1'b0;
        check("drop_sat", {24'd0, drop_cnt}, 255);
        check("stall_indef", {4'd0, led_last, led_idx, led_rgb}, {4'd0, 1'b0, 3'd0, 24'hEDEDED});

        // Reset while beat 5 is on the bus abandons the frame.
        led_ready = 1'b1;
        for (int c = 0; c < 100 && !(led_valid && led_idx == 3'd5); c++) tick;
        check("reach_beat5", {28'd0, led_valid, led_idx}, {28'd0, 1'b1, 3'd5});
        led_ready = 1'b0;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("rst_mid", {28'd0, led_valid, busy, frame_done, led_last}, 0);
        check("rst_drop_clr", {24'd0, drop_cnt}, 0);
        exp_q.delete();
        led_ready = 1'b1;
        repeat (20) tick;
        check("no_beats_after_rst", {30'd0, led_valid, busy}, 0);

        // Start with en low: ignored in IDLE and never counted while busy.
        en = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("en_low_idle", {30'd0, busy, led_valid}, 0);
        tick;
        check("en_low_no_drop", {24'd0, drop_cnt}, 0);
        en = 1'b1;
        start_frame(3);
        en = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        drive_frame(-1, -1, -1, b2b);
        check("en_fall_completes_no_drop", {24'd0, drop_cnt}, 0);
        tick;
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
